// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, runs a req/valid imem port, buffers one word when decode
// stalls, drains an outstanding request after a redirect and stops on HALT.
module fetch_stage #(
  parameter int                   PC_W      = 8,
  parameter int                   INSTR_W   = 16,
  parameter logic [PC_W-1:0]      RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               inc_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [4:0]         if_id_opcode,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic               halted
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALTED} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    tgt_q, tgt_d;        // redirect target parked while draining
  logic [INSTR_W-1:0] skid_q, skid_d;      // word caught during a stall
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic               halt_go;

  // Decode holds a HALT; a same-cycle flush squashes it instead.
  assign halt_go = ifid_valid_q & ~inc_pc & ~flush;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      tgt_q        <= '0;
      skid_q       <= NOP_INSTR;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      skid_q       <= skid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Next-state logic: flush beats halt, halt beats stall/fetch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (flush)                    state_d = imem_valid ? FETCH : DRAIN;
        else if (halt_go)             state_d = HALTED;
        else if (imem_valid && stall) state_d = HOLD;
      end
      HOLD: begin
        if (flush)                    state_d = FETCH;
        else if (halt_go)             state_d = HALTED;
        else if (!stall)              state_d = FETCH;
      end
      DRAIN: begin
        // The stale response retires the old request regardless of flush.
        if (imem_valid)               state_d = FETCH;
      end
      HALTED:                         state_d = HALTED;
      default:                        state_d = FETCH;
    endcase
  end

  // Datapath next values for PC, skid buffer and IF/ID.
  always_comb begin
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    skid_d       = skid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    if (state_q != HALTED && flush) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      tgt_d        = branch_target;
    end
    unique case (state_q)
      FETCH: begin
        if (flush) begin
          // Without a response the old address must stay on the bus.
          if (imem_valid) pc_d = branch_target;
        end else if (!halt_go && imem_valid) begin
          if (stall) begin
            skid_d = imem_rdata;
          end else begin
            ifid_instr_d = imem_rdata;
            ifid_pc_d    = pc_q;
            ifid_valid_d = 1'b1;
            pc_d         = pc_q + PC_W'(1);
          end
        end
      end
      HOLD: begin
        if (flush) begin
          pc_d = branch_target;
        end else if (!halt_go && !stall) begin
          ifid_instr_d = skid_q;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_q + PC_W'(1);
        end
      end
      DRAIN: begin
        if (imem_valid) pc_d = flush ? branch_target : tgt_q;
      end
      default: ;
    endcase
  end

  // Outputs; the request is forced low while reset is asserted.
  always_comb begin
    imem_req     = rst_n & ((state_q == FETCH) | (state_q == DRAIN));
    imem_addr    = pc_q;
    if_id_instr  = ifid_instr_q;
    if_id_opcode = ifid_instr_q[INSTR_W-1 -: 5];
    if_id_pc     = ifid_pc_q;
    if_id_valid  = ifid_valid_q;
    halted       = (state_q == HALTED);
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected IF/ID loads
// (pc, word, cycle), a monitor pops on every new IF/ID load.
module tb_fetch_stage;
  localparam int PC_W = 8, INSTR_W = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               imem_req, imem_valid, stall, flush, inc_pc;
  logic [PC_W-1:0]    imem_addr, branch_target, if_id_pc;
  logic [INSTR_W-1:0] imem_rdata, if_id_instr;
  logic [4:0]         if_id_opcode;
  logic               if_id_valid, halted;

  fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall), .flush(flush),
    .branch_target(branch_target), .inc_pc(inc_pc), .if_id_instr(if_id_instr),
    .if_id_opcode(if_id_opcode), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
    .halted(halted));

  // Instruction memory with programmable latency; mem_en=0 withholds responses.
  logic [INSTR_W-1:0] mem [256];
  logic mem_en = 1'b0;
  int   lat = 0, wcnt = 0;
  assign imem_valid = imem_req && mem_en && (wcnt >= lat);
  assign imem_rdata = mem[imem_addr];
  always @(posedge clk)
    if (!imem_req || !mem_en || imem_valid) wcnt <= 0;
    else wcnt <= wcnt + 1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [PC_W-1:0] pc; logic [INSTR_W-1:0] instr; int cyc; } exp_t;
  exp_t sbq[$];
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] w, input int c);
    exp_t e;
    e.pc = pc; e.instr = w; e.cyc = c;
    sbq.push_back(e);
  endtask

  // Monitor: a new IF/ID load is valid=1 with a pc differing from last cycle.
  logic pv = 1'b0;
  logic [PC_W-1:0] ppc = '0;
  exp_t me;
  always @(posedge clk) begin
    #1;
    if (!rst_n) pv = 1'b0;
    else begin
      if (if_id_valid && (!pv || if_id_pc !== ppc)) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_load: got pc %0h instr %0h expected none", if_id_pc, if_id_instr);
        end else begin
          me = sbq.pop_front();
          chk("ifid_pc", 32'(if_id_pc), 32'(me.pc));
          chk("ifid_instr", 32'(if_id_instr), 32'(me.instr));
          chk("ifid_opcode", 32'(if_id_opcode), 32'(me.instr[15:11]));
          chk("ifid_cycle", 32'(cyc), 32'(me.cyc));
        end
      end
      pv = if_id_valid; ppc = if_id_pc;
    end
  end

  // Request must hold its address until a response is accepted.
  logic hreq = 1'b0, hvld = 1'b0;
  logic [PC_W-1:0] haddr = '0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) hreq = 1'b0;
    else begin
      if (hreq && !hvld && imem_req) chk("addr_stable", 32'(imem_addr), 32'(haddr));
      hreq = imem_req; hvld = imem_valid; haddr = imem_addr;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {5'(i + 1), 3'b000, 8'(i + 1)};
    mem[255] = 16'hFA5F;
    stall = 0; flush = 0; branch_target = '0; inc_pc = 1;
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_valid", 32'(if_id_valid), 0);
    chk("rst_instr", 32'(if_id_instr), 0);
    chk("rst_halted", 32'(halted), 0);
    rst_n = 1;

    // Zero-wait: three back-to-back loads.
    @(negedge clk);
    mem_en = 1; lat = 0;
    push(8'h00, 16'h0801, cyc + 1);
    push(8'h01, 16'h1002, cyc + 2);
    push(8'h02, 16'h1803, cyc + 3);
    repeat (3) @(negedge clk);
    mem_en = 0;
    chk("t1_addr", 32'(imem_addr), 3);

    // Two-cycle latency: one load per response.
    lat = 2; mem_en = 1;
    push(8'h03, 16'h2004, cyc + 3);
    push(8'h04, 16'h2805, cyc + 6);
    repeat (6) @(negedge clk);
    mem_en = 0;
    chk("t2_addr", 32'(imem_addr), 5);

    // Stall for three cycles while word@5 returns.
    lat = 0; mem_en = 1; stall = 1;
    @(negedge clk);
    mem_en = 0;
    chk("hold_req", 32'(imem_req), 0);
    chk("hold_pc", 32'(if_id_pc), 4);
    repeat (2) @(negedge clk);
    chk("hold_instr", 32'(if_id_instr), 16'h2805);
    stall = 0;
    push(8'h05, 16'h3006, cyc + 1);
    @(negedge clk);
    chk("t3_addr", 32'(imem_addr), 6);

    // Flush with a request outstanding: drain the stale word, fetch 0x40.
    flush = 1; branch_target = 8'h40;
    @(negedge clk);
    flush = 0;
    chk("drain_req", 32'(imem_req), 1);
    chk("drain_addr", 32'(imem_addr), 6);
    chk("drain_valid", 32'(if_id_valid), 0);
    mem_en = 1; lat = 1;
    push(8'h40, 16'h0841, cyc + 4);
    repeat (2) @(negedge clk);
    chk("t4_addr", 32'(imem_addr), 8'h40);
    repeat (2) @(negedge clk);
    mem_en = 0;

    // HALT in IF/ID together with flush: flush wins.
    inc_pc = 0; flush = 1; branch_target = 8'h80;
    @(negedge clk);
    flush = 0; inc_pc = 1;
    chk("nohalt", 32'(halted), 0);
    chk("squash_valid", 32'(if_id_valid), 0);
    chk("squash_instr", 32'(if_id_instr), 0);
    mem_en = 1; lat = 0;
    push(8'h80, 16'h0881, cyc + 2);
    repeat (2) @(negedge clk);

    // HALT: stop next cycle, ignore flush/stall afterwards.
    inc_pc = 0;
    @(negedge clk);
    chk("halted", 32'(halted), 1);
    chk("halt_req", 32'(imem_req), 0);
    chk("halt_pc", 32'(if_id_pc), 8'h80);
    chk("halt_valid", 32'(if_id_valid), 1);
    flush = 1; stall = 1; branch_target = 8'h10;
    @(negedge clk);
    flush = 0; stall = 0;
    chk("halt_sticky", 32'(halted), 1);
    chk("halt_sticky_req", 32'(imem_req), 0);
    chk("halt_frozen", 32'(if_id_instr), 16'h0881);
    mem_en = 0; inc_pc = 1;

    // Reset leaves HALTED; PC wrap from 0xFF.
    rst_n = 0;
    @(negedge clk);
    chk("unhalt", 32'(halted), 0);
    rst_n = 1;
    flush = 1; branch_target = 8'hFF;
    @(negedge clk);
    flush = 0; mem_en = 1; lat = 0;
    push(8'hFF, 16'hFA5F, cyc + 2);
    repeat (2) @(negedge clk);
    mem_en = 0;
    chk("wrap_addr", 32'(imem_addr), 0);

    // Reset asserted mid-DRAIN takes effect immediately.
    flush = 1; branch_target = 8'h10;
    @(negedge clk);
    flush = 0;
    chk("md_req", 32'(imem_req), 1);
    #3 rst_n = 0;
    #1;
    chk("mdrst_req", 32'(imem_req), 0);
    chk("mdrst_addr", 32'(imem_addr), 0);
    chk("mdrst_pc", 32'(if_id_pc), 0);
    chk("mdrst_valid", 32'(if_id_valid), 0);
    chk("mdrst_instr", 32'(if_id_instr), 0);
    chk("mdrst_halted", 32'(halted), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
